// File: rtl/car_sequencer.sv
// Control Address Register microsequencer: fetch/execute stepping with IR latch,
// memory-wait stall, boundary-only interrupt entry, illegal-opcode trap and step watchdog.
module car_sequencer #(
    parameter int CAR_BITS  = 6,
    parameter int CAR_FETCH = 0,
    parameter int CAR_IRQ0  = 60,
    parameter int CAR_TRAP0 = 62,
    parameter int MAX_STEPS = 16
) (
    input  logic                MCLK,
    input  logic                RST_n,
    input  logic [15:0]         IW,
    input  logic                iw_valid,
    input  logic [CAR_BITS-1:0] start_car,
    input  logic [CAR_BITS-1:0] uop_next,
    input  logic                uop_last,
    input  logic                stall,
    input  logic                irq_req,
    output logic [CAR_BITS-1:0] CAR,
    output logic [15:0]         IR,
    output logic                iw_accept,
    output logic                irq_ack,
    output logic                illegal,
    output logic                wdt_fault,
    output logic                busy
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [CAR_BITS-1:0] CAR_FETCH_C = CAR_BITS'(CAR_FETCH);
    localparam logic [CAR_BITS-1:0] CAR_IRQ0_C  = CAR_BITS'(CAR_IRQ0);
    localparam logic [CAR_BITS-1:0] CAR_TRAP0_C = CAR_BITS'(CAR_TRAP0);
    localparam logic [STEP_W-1:0]   STEP_MAX_C  = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0]   STEP_ONE_C  = STEP_W'(1);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CAR_BITS-1:0] car_q, car_d;
    logic [15:0]         ir_q, ir_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic                iw_accept_q, iw_accept_d;
    logic                irq_ack_q, irq_ack_d;
    logic                illegal_q, illegal_d;
    logic                wdt_fault_q, wdt_fault_d;

    // Next-state decode; stall leaves every register at its held value with pulses cleared.
    always_comb begin
        state_d     = state_q;
        car_d       = car_q;
        ir_d        = ir_q;
        step_cnt_d  = step_cnt_q;
        iw_accept_d = 1'b0;
        irq_ack_d   = 1'b0;
        illegal_d   = 1'b0;
        wdt_fault_d = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_FETCH: begin
                    // Interrupt wins over a delivered word; the fetch stays unconsumed.
                    if (irq_req) begin
                        car_d      = CAR_IRQ0_C;
                        irq_ack_d  = 1'b1;
                        state_d    = ST_EXEC;
                        step_cnt_d = STEP_ONE_C;
                    end else if (iw_valid) begin
                        ir_d        = IW;
                        iw_accept_d = 1'b1;
                        state_d     = ST_EXEC;
                        step_cnt_d  = STEP_ONE_C;
                        if (start_car == CAR_FETCH_C) begin
                            illegal_d = 1'b1;
                            car_d     = CAR_TRAP0_C;
                        end else begin
                            car_d = start_car;
                        end
                    end else begin
                        car_d = CAR_FETCH_C;
                    end
                end
                ST_EXEC: begin
                    if (uop_last) begin
                        car_d      = CAR_FETCH_C;
                        state_d    = ST_FETCH;
                        step_cnt_d = '0;
                    end else if (step_cnt_q == STEP_MAX_C) begin
                        wdt_fault_d = 1'b1;
                        car_d       = CAR_FETCH_C;
                        state_d     = ST_FETCH;
                        step_cnt_d  = '0;
                    end else begin
                        car_d      = uop_next;
                        step_cnt_d = (step_cnt_q == STEP_MAX_C) ? step_cnt_q : step_cnt_q + STEP_ONE_C;
                    end
                end
                default: begin
                    state_d    = ST_FETCH;
                    car_d      = CAR_FETCH_C;
                    step_cnt_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, CAR, IR, step counter and pulse registers.
    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= ST_FETCH;
            car_q       <= CAR_FETCH_C;
            ir_q        <= 16'h0000;
            step_cnt_q  <= '0;
            iw_accept_q <= 1'b0;
            irq_ack_q   <= 1'b0;
            illegal_q   <= 1'b0;
            wdt_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            car_q       <= car_d;
            ir_q        <= ir_d;
            step_cnt_q  <= step_cnt_d;
            iw_accept_q <= iw_accept_d;
            irq_ack_q   <= irq_ack_d;
            illegal_q   <= illegal_d;
            wdt_fault_q <= wdt_fault_d;
        end
    end

    assign CAR       = car_q;
    assign IR        = ir_q;
    assign iw_accept = iw_accept_q;
    assign irq_ack   = irq_ack_q;
    assign illegal   = illegal_q;
    assign wdt_fault = wdt_fault_q;
    assign busy      = (state_q != ST_FETCH);

endmodule
